// File: rtl/single_cycle_cpu.sv
// single_cycle_cpu: RV32I-subset core that retires one instruction per clock.
// Internal instruction ROM, 32x32 register file and word-addressed data RAM.
// Each edge updates PC, rd and dmem together. All other logic is combinational from PC.
// Optional feature: define SCCPU_MUL_EN to decode MUL (rd = low 32 bits of rs1*rs2).
// IMEM_DEPTH and DMEM_DEPTH are expected to be powers of two, so that the
// memory indices wrap modulo the depth.
module single_cycle_cpu #(
  parameter int    IMEM_DEPTH     = 256,
  parameter int    DMEM_DEPTH     = 256,
  parameter string IMEM_INIT_FILE = "program.hex"
) (
  input  logic clk,
  input  logic reset
);

  localparam int IAW = (IMEM_DEPTH > 1) ? $clog2(IMEM_DEPTH) : 1;
  localparam int DAW = (DMEM_DEPTH > 1) ? $clog2(DMEM_DEPTH) : 1;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
    ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA, ALU_MUL
  } alu_op_e;

  typedef enum logic [1:0] {WB_ALU, WB_MEM, WB_PC4} wb_sel_e;

  // Architectural state, observed hierarchically by benches.
  logic [31:0] PC;
  logic [31:0] regs [32];
  logic [31:0] dmem [DMEM_DEPTH];
  logic [31:0] imem [IMEM_DEPTH];

  // ROM image: NOP everywhere.
  initial begin
    for (int i = 0; i < IMEM_DEPTH; i++) imem[i] = NOP_INSTR;
  end

  // Fetch and field extraction.
  logic [31:0] instr;
  logic [6:0]  opcode, funct7;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;

  assign instr  = imem[PC[IAW+1:2]];
  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign funct3 = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign funct7 = instr[31:25];

  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'b0};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  // x0 is hard-wired; a same-cycle write is not bypassed (old value is read).
  logic [31:0] rs1_val, rs2_val, pc_plus4;
  assign rs1_val  = (rs1 == 5'd0) ? 32'd0 : regs[rs1];
  assign rs2_val  = (rs2 == 5'd0) ? 32'd0 : regs[rs2];
  assign pc_plus4 = PC + 32'd4;

  function automatic logic [31:0] alu(alu_op_e op, logic [31:0] a, logic [31:0] b);
    logic [4:0] sh;
    sh = b[4:0];
    case (op)
      ALU_SUB:  alu = a - b;
      ALU_AND:  alu = a & b;
      ALU_OR:   alu = a | b;
      ALU_XOR:  alu = a ^ b;
      ALU_SLT:  alu = {31'b0, $signed(a) < $signed(b)};
      ALU_SLTU: alu = {31'b0, a < b};
      ALU_SLL:  alu = a << sh;
      ALU_SRL:  alu = a >> sh;
      ALU_SRA:  alu = $signed(a) >>> sh;
`ifdef SCCPU_MUL_EN
      ALU_MUL:  alu = a * b;
`endif
      default:  alu = a + b;
    endcase
  endfunction

  // Decode controls.
  alu_op_e     alu_op;
  wb_sel_e     wb_sel;
  logic [31:0] alu_a, alu_b;
  logic        reg_we, mem_we, is_branch, is_jal, is_jalr;

  // Decode: unsupported encodings fall through to defaults, which act as a NOP.
  always_comb begin
    // NOTE: every output gets a default before the case, so no path leaves a
    // signal unassigned and no latch is inferred.
    alu_op    = ALU_ADD;
    wb_sel    = WB_ALU;
    alu_a     = rs1_val;
    alu_b     = rs2_val;
    reg_we    = 1'b0;
    mem_we    = 1'b0;
    is_branch = 1'b0;
    is_jal    = 1'b0;
    is_jalr   = 1'b0;
    case (opcode)
      OP_R: begin
        reg_we = 1'b1;
        if (funct7 == 7'b0000000) begin
          case (funct3)
            3'b000:  alu_op = ALU_ADD;
            3'b001:  alu_op = ALU_SLL;
            3'b010:  alu_op = ALU_SLT;
            3'b011:  alu_op = ALU_SLTU;
            3'b100:  alu_op = ALU_XOR;
            3'b101:  alu_op = ALU_SRL;
            3'b110:  alu_op = ALU_OR;
            default: alu_op = ALU_AND;
          endcase
        end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
          alu_op = ALU_SUB;
        end else if (funct7 == 7'b0100000 && funct3 == 3'b101) begin
          alu_op = ALU_SRA;
`ifdef SCCPU_MUL_EN
        end else if (funct7 == 7'b0000001 && funct3 == 3'b000) begin
          alu_op = ALU_MUL;
`endif
        end else begin
          reg_we = 1'b0;
        end
      end
      OP_I: begin
        alu_b  = imm_i;
        reg_we = 1'b1;
        case (funct3)
          3'b000: alu_op = ALU_ADD;
          3'b010: alu_op = ALU_SLT;
          3'b011: alu_op = ALU_SLTU;
          3'b100: alu_op = ALU_XOR;
          3'b110: alu_op = ALU_OR;
          3'b111: alu_op = ALU_AND;
          3'b001: begin
            alu_op = ALU_SLL;
            reg_we = (funct7 == 7'b0000000);
          end
          default: begin
            alu_op = (funct7 == 7'b0100000) ? ALU_SRA : ALU_SRL;
            reg_we = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
          end
        endcase
      end
      OP_LOAD: begin
        alu_b  = imm_i;
        wb_sel = WB_MEM;
        reg_we = (funct3 == 3'b010);
      end
      OP_STORE: begin
        alu_b  = imm_s;
        mem_we = (funct3 == 3'b010);
      end
      OP_BRANCH: begin
        is_branch = (funct3 == 3'b000) || (funct3 == 3'b001) ||
                    (funct3 == 3'b100) || (funct3 == 3'b101);
      end
      OP_JAL: begin
        is_jal = 1'b1;
        wb_sel = WB_PC4;
        reg_we = 1'b1;
      end
      OP_JALR: begin
        is_jalr = (funct3 == 3'b000);
        reg_we  = (funct3 == 3'b000);
        wb_sel  = WB_PC4;
      end
      OP_LUI: begin
        alu_a  = 32'd0;
        alu_b  = imm_u;
        reg_we = 1'b1;
      end
      OP_AUIPC: begin
        alu_a  = PC;
        alu_b  = imm_u;
        reg_we = 1'b1;
      end
      default: ;
    endcase
  end

  logic [31:0] alu_result, mem_rdata, wb_data, next_pc, jalr_target;
  logic        branch_taken;

  assign alu_result  = alu(alu_op, alu_a, alu_b);
  assign mem_rdata   = dmem[alu_result[DAW+1:2]];
  assign jalr_target = (rs1_val + imm_i) & ~32'd1;

  // Writeback mux and next-PC selection.
  always_comb begin
    branch_taken = 1'b0;
    next_pc      = pc_plus4;
    case (wb_sel)
      WB_MEM:  wb_data = mem_rdata;
      WB_PC4:  wb_data = pc_plus4;
      default: wb_data = alu_result;
    endcase
    if (is_branch) begin
      case (funct3)
        3'b000:  branch_taken = (rs1_val == rs2_val);
        3'b001:  branch_taken = (rs1_val != rs2_val);
        3'b100:  branch_taken = ($signed(rs1_val) <  $signed(rs2_val));
        default: branch_taken = ($signed(rs1_val) >= $signed(rs2_val));
      endcase
    end
    if (branch_taken)  next_pc = PC + imm_b;
    else if (is_jal)   next_pc = PC + imm_j;
    else if (is_jalr)  next_pc = jalr_target;
  end

  // Program counter register.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: state registers use non-blocking assignment so every flop samples
    // the pre-edge values and PC, rd and dmem commit together.
    if (reset) PC <= 32'd0;
    else       PC <= next_pc;
  end

  // Register file write port; x0 writes are discarded.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) regs[i] <= 32'd0;
    end else if (reg_we && rd != 5'd0) begin
      regs[rd] <= wb_data;
    end
  end

  // Data RAM write port.
  always_ff @(posedge clk) begin
    // NOTE: the RAM array has no reset so it maps onto memory macros; contents
    // survive a core reset.
    if (mem_we && !reset) dmem[alu_result[DAW+1:2]] <= rs2_val;
  end

  // Address bits that play no part in word indexing.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{PC[1:0], PC[31:IAW+2], alu_result[1:0], alu_result[31:DAW+2]};

endmodule

// File: tb/tb_single_cycle_cpu.sv
// tb_single_cycle_cpu: directed programs for single_cycle_cpu with hand-computed
// results. Programs are written into the ROM hierarchically while reset is held.
// Define SCCPU_MUL_EN for both bench and RTL to exercise MUL.
module tb_single_cycle_cpu;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LOAD = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011, OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_vec = 0;
  int   n_miscompare = 0;
  logic [31:0] prog [32];

  single_cycle_cpu #(.IMEM_INIT_FILE("")) dut (.clk(clk), .reset(reset));

  always #25 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miscompare++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, OP_R};
  endfunction

  function automatic logic [31:0] enc_i(input logic [31:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {imm[11:0], rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_s(input logic [31:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], OP_STORE};
  endfunction

  function automatic logic [31:0] enc_b(input logic [31:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] enc_j(input logic [31:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
  endfunction

  function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {imm, rd, op};
  endfunction

  task automatic clear_prog();
    for (int i = 0; i < 32; i++) prog[i] = NOP;
  endtask

  // Hold reset, install prog[] over an all-NOP ROM, release on a falling edge.
  task automatic load_and_start();
    reset = 1'b1;
    #1;
    for (int i = 0; i < 256; i++) dut.imem[i] = NOP;
    for (int i = 0; i < 32; i++) dut.imem[i] = prog[i];
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Advance n rising edges and settle 1 ns past the last one.
  task automatic run(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  logic [31:0] acc;
  logic [31:0] exp_pc [11];

  initial begin
    // All-NOP image, reset held over the first edge (t=25).
    #30;
    check("reset_pc_held", dut.PC, 32'd0);
    #20;
    reset = 1'b0;
    for (int n = 1; n <= 100; n++) begin
      @(posedge clk);
      #1;
      check($sformatf("nop_pc_%0d", n), dut.PC, 32'(4 * n));
    end
    acc = '0;
    for (int i = 0; i < 32; i++) acc = acc | dut.regs[i];
    check("nop_regs_zero", acc, 32'd0);

    // ALU and x0.
    clear_prog();
    prog[0]  = enc_i(32'd5, 0, 3'b000, 1, OP_I);          // addi x1,x0,5
    prog[1]  = enc_i(32'd7, 0, 3'b000, 2, OP_I);          // addi x2,x0,7
    prog[2]  = enc_r(7'h00, 2, 1, 3'b000, 3);             // add  x3,x1,x2
    prog[3]  = enc_r(7'h20, 2, 1, 3'b000, 4);             // sub  x4,x1,x2
    prog[4]  = enc_r(7'h00, 1, 4, 3'b010, 5);             // slt  x5,x4,x1
    prog[5]  = enc_i(32'h401, 4, 3'b101, 6, OP_I);        // srai x6,x4,1
    prog[6]  = enc_i(32'd9, 0, 3'b000, 0, OP_I);          // addi x0,x0,9
    prog[7]  = enc_r(7'h00, 1, 4, 3'b011, 7);             // sltu x7,x4,x1
    prog[8]  = enc_r(7'h00, 2, 1, 3'b100, 8);             // xor  x8,x1,x2
    prog[9]  = enc_r(7'h00, 2, 1, 3'b001, 9);             // sll  x9,x1,x2
    prog[10] = enc_r(7'h00, 2, 4, 3'b101, 10);            // srl  x10,x4,x2
    prog[11] = enc_r(7'h20, 2, 4, 3'b101, 13);            // sra  x13,x4,x2
    prog[12] = enc_r(7'h00, 2, 1, 3'b111, 14);            // and  x14,x1,x2
    prog[13] = enc_r(7'h00, 2, 1, 3'b110, 15);            // or   x15,x1,x2
    prog[14] = enc_i(32'h0F0, 4, 3'b111, 11, OP_I);       // andi x11,x4,0xF0
    prog[15] = enc_i(32'hFF0, 1, 3'b110, 12, OP_I);       // ori  x12,x1,-16
    prog[16] = enc_i(32'hFFF, 4, 3'b010, 16, OP_I);       // slti x16,x4,-1
    prog[17] = enc_i(32'd6, 1, 3'b011, 17, OP_I);         // sltiu x17,x1,6
    prog[18] = enc_i(32'd3, 2, 3'b001, 18, OP_I);         // slli x18,x2,3
    prog[19] = enc_i(32'd28, 4, 3'b101, 19, OP_I);        // srli x19,x4,28
    prog[20] = enc_i(32'hFFF, 1, 3'b100, 20, OP_I);       // xori x20,x1,-1
    load_and_start();
    run(21);
    check("alu_pc", dut.PC, 32'd84);
    check("add_x3", dut.regs[3], 32'd12);
    check("sub_x4", dut.regs[4], 32'hFFFF_FFFE);
    check("slt_x5", dut.regs[5], 32'd1);
    check("srai_x6", dut.regs[6], 32'hFFFF_FFFF);
    check("x0_zero", dut.regs[0], 32'd0);
    check("sltu_x7", dut.regs[7], 32'd0);
    check("xor_x8", dut.regs[8], 32'd2);
    check("sll_x9", dut.regs[9], 32'd640);
    check("srl_x10", dut.regs[10], 32'h01FF_FFFF);
    check("sra_x13", dut.regs[13], 32'hFFFF_FFFF);
    check("and_x14", dut.regs[14], 32'd5);
    check("or_x15", dut.regs[15], 32'd7);
    check("andi_x11", dut.regs[11], 32'h0000_00F0);
    check("ori_x12", dut.regs[12], 32'hFFFF_FFF5);
    check("slti_x16", dut.regs[16], 32'd1);
    check("sltiu_x17", dut.regs[17], 32'd1);
    check("slli_x18", dut.regs[18], 32'd56);
    check("srli_x19", dut.regs[19], 32'h0000_000F);
    check("xori_x20", dut.regs[20], 32'hFFFF_FFFA);

    // Memory: word access, low address bits ignored, index wraps at 256 words.
    clear_prog();
    prog[0] = enc_i(32'h55, 0, 3'b000, 1, OP_I);          // addi x1,x0,0x55
    prog[1] = enc_s(32'd8, 1, 0, 3'b010);                 // sw   x1,8(x0)
    prog[2] = enc_i(32'd8, 0, 3'b010, 7, OP_LOAD);        // lw   x7,8(x0)
    prog[3] = enc_i(32'd9, 0, 3'b010, 8, OP_LOAD);        // lw   x8,9(x0)
    prog[4] = enc_i(32'd1032, 0, 3'b010, 9, OP_LOAD);     // lw   x9,1032(x0)
    load_and_start();
    run(5);
    check("sw_dmem2", dut.dmem[2], 32'h55);
    check("lw_x7", dut.regs[7], 32'h55);
    check("lw_x8_lowbits", dut.regs[8], 32'h55);
    check("lw_x9_wrap", dut.regs[9], 32'h55);

    // Control flow, PC checked after every edge.
    clear_prog();
    prog[0]  = enc_b(32'd8, 0, 0, 3'b000);                // 0:  beq x0,x0,+8
    prog[1]  = enc_i(32'd1, 0, 3'b000, 5, OP_I);          // 4:  addi x5,x0,1 (skipped)
    prog[2]  = enc_b(32'd8, 0, 0, 3'b001);                // 8:  bne x0,x0,+8
    prog[3]  = enc_j(32'd16, 1);                          // 12: jal x1,+16
    prog[4]  = enc_u(20'h12345, 2, OP_LUI);               // 16: lui x2,0x12345
    prog[5]  = enc_i(32'hFFF, 0, 3'b000, 3, OP_I);        // 20: addi x3,x0,-1
    prog[6]  = enc_b(32'd8, 0, 3, 3'b100);                // 24: blt x3,x0,+8
    prog[7]  = enc_i(32'd1, 1, 3'b000, 0, OP_JALR);       // 28: jalr x0,1(x1)
    prog[8]  = enc_b(32'd8, 0, 3, 3'b101);                // 32: bge x3,x0,+8
    prog[9]  = enc_b(32'd12, 3, 0, 3'b101);               // 36: bge x0,x3,+12
    prog[12] = enc_u(20'h00001, 4, OP_AUIPC);             // 48: auipc x4,1
    prog[13] = enc_i(32'h40, 0, 3'b000, 6, OP_JALR);      // 52: jalr x6,0x40(x0)
    exp_pc = '{32'd8, 32'd12, 32'd28, 32'd16, 32'd20, 32'd24,
               32'd32, 32'd36, 32'd48, 32'd52, 32'd64};
    load_and_start();
    for (int n = 0; n < 11; n++) begin
      run(1);
      check($sformatf("flow_pc_%0d", n + 1), dut.PC, exp_pc[n]);
    end
    check("skipped_x5", dut.regs[5], 32'd0);
    check("jal_x1", dut.regs[1], 32'd16);
    check("lui_x2", dut.regs[2], 32'h1234_5000);
    check("addi_neg_x3", dut.regs[3], 32'hFFFF_FFFF);
    check("auipc_x4", dut.regs[4], 32'h0000_1030);
    check("jalr_link_x6", dut.regs[6], 32'd56);

    // MUL (optional) and unsupported encodings behaving as NOPs.
    clear_prog();
    prog[0] = enc_i(32'hFFD, 0, 3'b000, 1, OP_I);         // addi x1,x0,-3
    prog[1] = enc_i(32'd7, 0, 3'b000, 2, OP_I);           // addi x2,x0,7
    prog[2] = enc_r(7'h01, 2, 1, 3'b000, 3);              // mul  x3,x1,x2
    prog[3] = 32'hFFFF_FFFF;                              // illegal opcode
    prog[4] = enc_i(32'd8, 0, 3'b000, 9, OP_LOAD);        // lb   x9,8(x0): unsupported
    prog[5] = enc_r(7'h20, 2, 1, 3'b111, 10);             // bad funct7 on AND
    load_and_start();
    run(6);
    check("unsup_pc", dut.PC, 32'd24);
`ifdef SCCPU_MUL_EN
    check("mul_x3", dut.regs[3], 32'hFFFF_FFEB);
`else
    check("mul_off_x3", dut.regs[3], 32'd0);
`endif
    check("unsup_lb_x9", dut.regs[9], 32'd0);
    check("unsup_r_x10", dut.regs[10], 32'd0);

    // Asynchronous reset mid-run.
    clear_prog();
    prog[0] = enc_i(32'd5, 0, 3'b000, 1, OP_I);           // addi x1,x0,5
    load_and_start();
    run(10);
    check("mid_pc_before", dut.PC, 32'd40);
    check("mid_x1_before", dut.regs[1], 32'd5);
    #9;
    reset = 1'b1;
    #1;
    check("mid_pc_async", dut.PC, 32'd0);
    check("mid_x1_cleared", dut.regs[1], 32'd0);
    run(1);
    check("mid_pc_held", dut.PC, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    run(3);
    check("mid_pc_resume", dut.PC, 32'd12);
    check("mid_x1_resume", dut.regs[1], 32'd5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscompare);
    $finish;
  end

endmodule
